// File: rtl/pipe_add_n.sv
// rtl/pipe_add_n.sv - carry-pipelined add/subtract unit with valid/ready flow control
//
// Splits a WIDTH-bit adder into SEGS segments of WIDTH/SEGS bits. Segment k is
// resolved in pipeline stage k; the carry between segments is registered, and
// the operand bits of later segments are skewed through registers so that they
// meet their carry in the right stage. The result appears SEGS cycles after
// the operand set is accepted.
//
// Optional build macro: PIPE_ADD_N_SAT_EN enables saturation of S on overflow
// (all ones in add mode, all zeros in subtract mode).
//
// Parameters:
//   WIDTH     operand and sum width, at least 2
//   SEGS      number of carry-pipeline segments, WIDTH must be a multiple of SEGS
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   IN_VALID  operand set presented
//   IN_READY  operand set accepted this cycle (equals the pipeline advance)
//   A, B      operands
//   CI        carry-in (add) or borrow-in (subtract)
//   SUB       0 = add, 1 = subtract, captured with the operands
//   OUT_VALID S/CO/OVF hold a valid result
//   OUT_READY consumer takes the result this cycle
//   S         sum or difference
//   CO        carry-out; in subtract mode 1 means no borrow
//   OVF       unsigned overflow (add) or underflow (subtract)

module pipe_add_n #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);

    localparam int SW   = WIDTH / SEGS;
    localparam int LAST = SEGS - 1;

    // The whole pipeline moves as one: it advances whenever the output slot is
    // empty or being drained this cycle.
    logic adv;

    assign adv      = ~OUT_VALID | OUT_READY;
    assign IN_READY = adv;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        // Operand bits still to be consumed when entering stage k.
        localparam int IN_W  = WIDTH - k * SW;
        localparam int SUM_W = (k + 1) * SW;

        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic             c_in;
        logic             sub_in;
        logic             valid_in;
        logic [SW:0]      seg;
        logic [SUM_W-1:0] sum_nxt;

        // Stage k results: partial sum of segments 0..k, its carry, mode, valid.
        logic [SUM_W-1:0] sum_q;
        logic             carry_q;
        logic             sub_q;
        logic             valid_q;

        assign seg = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        if (k == 0) begin : g_head
            // Subtract is A + ~B + ~CI; inverting here lets every segment use
            // the same plain adder.
            assign a_in     = A;
            assign b_in     = SUB ? ~B : B;
            assign c_in     = SUB ? ~CI : CI;
            assign sub_in   = SUB;
            assign valid_in = IN_VALID;
            assign sum_nxt  = seg[SW-1:0];
        end else begin : g_body
            // Skew registers: operand bits for segments k.. travel alongside
            // the partial result of stage k-1.
            logic [IN_W-1:0] a_q;
            logic [IN_W-1:0] b_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= g_stage[k-1].a_in[IN_W+SW-1:SW];
                    b_q <= g_stage[k-1].b_in[IN_W+SW-1:SW];
                end
            end

            assign a_in     = a_q;
            assign b_in     = b_q;
            assign c_in     = g_stage[k-1].carry_q;
            assign sub_in   = g_stage[k-1].sub_q;
            assign valid_in = g_stage[k-1].valid_q;
            assign sum_nxt  = {seg[SW-1:0], g_stage[k-1].sum_q};
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                sub_q   <= 1'b0;
                valid_q <= 1'b0;
            end else if (adv) begin
                sum_q   <= sum_nxt;
                carry_q <= seg[SW];
                sub_q   <= sub_in;
                valid_q <= valid_in;
            end
        end
    end

    logic [WIDTH-1:0] sum_w;
    logic             sub_w;

    assign sum_w     = g_stage[LAST].sum_q;
    assign sub_w     = g_stage[LAST].sub_q;
    assign OUT_VALID = g_stage[LAST].valid_q;
    assign CO        = g_stage[LAST].carry_q;
    // In subtract mode a carry-out of 1 means no borrow, so underflow is ~CO.
    assign OVF       = sub_w ? ~CO : CO;

`ifdef PIPE_ADD_N_SAT_EN
    assign S = OVF ? (sub_w ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : sum_w;
`else
    assign S = sum_w;
`endif

endmodule

// File: tb/tb_pipe_add_n.sv
// tb/tb_pipe_add_n.sv - directed self-checking bench for pipe_add_n

module tb_pipe_add_n;

    localparam int WIDTH = 16;
    localparam int SEGS  = 4;

`ifdef PIPE_ADD_N_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             SUB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             OVF;

    int n_checks = 0;
    int n_errors = 0;

    pipe_add_n #(.WIDTH(WIDTH), .SEGS(SEGS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CI        (CI),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .CO        (CO),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: plain integer add / subtract with borrow, returns {ovf, co, s}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub);
        logic [16:0] r;
        logic        co;
        logic        ovf;
        logic [15:0] s;
        if (!sub) begin
            r   = {1'b0, a} + {1'b0, b} + 17'(ci);
            co  = r[16];
            ovf = co;
        end else begin
            r   = {1'b0, a} - {1'b0, b} - 17'(ci);
            co  = ~r[16];
            ovf = r[16];
        end
        s = r[15:0];
        if (SAT && ovf) s = sub ? 16'h0000 : 16'hFFFF;
        return {ovf, co, s};
    endfunction

    // One isolated operand set: checks the exact latency and the result.
    task automatic send_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic sub, input logic [15:0] exp_s,
                               input logic exp_co, input logic exp_ovf);
        A         = a;
        B         = b;
        CI        = ci;
        SUB       = sub;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        #1;
        check_eq({tag, ".in_ready"}, 32'(IN_READY), 32'd1);
        step();
        IN_VALID = 1'b0;
        for (int i = 1; i < SEGS; i++) begin
            check_eq({tag, ".early"}, 32'(OUT_VALID), 32'd0);
            step();
        end
        check_eq({tag, ".valid"}, 32'(OUT_VALID), 32'd1);
        check_eq({tag, ".s"}, 32'(S), 32'(exp_s));
        check_eq({tag, ".co"}, 32'(CO), 32'(exp_co));
        check_eq({tag, ".ovf"}, 32'(OVF), 32'(exp_ovf));
        step();
        check_eq({tag, ".drained"}, 32'(OUT_VALID), 32'd0);
    endtask

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vci [8];
    logic        vsub [8];
    logic [17:0] exp_q [$];
    logic [17:0] exp_r;
    logic [15:0] held_s;
    logic        stalled;
    int          idx;
    int          got;
    int          cyc;

    initial begin
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        A         = '0;
        B         = '0;
        CI        = 1'b0;
        SUB       = 1'b0;
        OUT_READY = 1'b1;
        step();
        step();
        RST = 1'b0;

        check_eq("rst.out_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst.in_ready", 32'(IN_READY), 32'd1);
        check_eq("rst.s", 32'(S), 32'd0);
        check_eq("rst.co", 32'(CO), 32'd0);
        check_eq("rst.ovf", 32'(OVF), 32'd0);

        send_single("add_ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        send_single("add_ffff_c", 16'hFFFF, 16'h0000, 1'b1, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b1);
        send_single("sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, SAT ? 16'h0000 : 16'hFFFE, 1'b0, 1'b1);
        send_single("sub_7_5",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        send_single("sub_5_5_b",  16'h0005, 16'h0005, 1'b1, 1'b1, SAT ? 16'h0000 : 16'hFFFF, 1'b0, 1'b1);
        send_single("add_mixed",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        send_single("add_ripple", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        send_single("add_8000",   16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b1);

        // Back-to-back stream with the consumer stalling in cycles 6-8.
        for (int i = 0; i < 8; i++) begin
            va[i]   = 16'(16'h2345 * i + 16'h0F0F);
            vb[i]   = 16'(16'h1357 * (7 - i) + 16'h00F1);
            vci[i]  = 1'(i >> 1);
            vsub[i] = 1'(i);
        end
        idx     = 0;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held_s  = '0;
        while (got < 8 && cyc < 60) begin
            cyc++;
            OUT_READY = !(cyc >= 6 && cyc <= 8);
            if (idx < 8) begin
                A        = va[idx];
                B        = vb[idx];
                CI       = vci[idx];
                SUB      = vsub[idx];
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (OUT_VALID && !OUT_READY) begin
                check_eq("stall.in_ready", 32'(IN_READY), 32'd0);
                if (stalled) check_eq("stall.s_stable", 32'(S), 32'(held_s));
                held_s  = S;
                stalled = 1'b1;
            end
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream.unexpected", 32'(OUT_VALID), 32'd0);
                end else begin
                    exp_r = exp_q.pop_front();
                    check_eq("stream.result", {14'd0, OVF, CO, S}, {14'd0, exp_r});
                end
                got++;
            end
            if (IN_VALID && IN_READY) begin
                exp_q.push_back(model(A, B, CI, SUB));
                idx++;
            end
            step();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        check_eq("stream.count", 32'(got), 32'd8);
        check_eq("stream.stall_seen", 32'(stalled), 32'd1);
        step();
        check_eq("stream.idle", 32'(OUT_VALID), 32'd0);

        // Reset in flight: three accepts, first result parked at the output,
        // then reset with a fresh input also presented.
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A        = 16'(16'h0101 * (i + 1));
            B        = 16'h0011;
            CI       = 1'b0;
            SUB      = 1'b0;
            IN_VALID = 1'b1;
            step();
        end
        IN_VALID = 1'b0;
        step();
        check_eq("mid.pre_rst_valid", 32'(OUT_VALID), 32'd1);
        RST       = 1'b1;
        OUT_READY = 1'b1;
        A         = 16'h7777;
        B         = 16'h1111;
        IN_VALID  = 1'b1;
        step();
        RST      = 1'b0;
        IN_VALID = 1'b0;
        check_eq("mid.rst_valid", 32'(OUT_VALID), 32'd0);
        check_eq("mid.rst_s", 32'(S), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("mid.no_ghost", 32'(OUT_VALID), 32'd0);
        end
        send_single("post_rst", 16'h0A0A, 16'h0505, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
